// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch responder: NOP encoding,
// FSM state type and the line-tag extraction helper.
package mips_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [0:0] {
        IFR_IDLE,
        IFR_REFILL
    } ifr_state_t;

    // Tag is everything above the byte offset and the word-in-line index.
    // Operates at a fixed 64-bit width so callers of any ADDR_W can share it.
    function automatic logic [63:0] line_tag(input logic [63:0] pc,
                                             input int unsigned line_words);
        return pc >> (2 + $clog2(line_words));
    endfunction

endpackage

// File: rtl/ifr_line_buffer.sv
// Single-line instruction buffer: tag, valid bit and LINE_WORDS data words,
// with one write port for refill beats and one combinational read port.
module ifr_line_buffer #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned IDX_W      = 2,
    parameter int unsigned TAG_W      = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_valid,
    input  logic             set_valid,
    input  logic             tag_we,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata,
    output logic             valid,
    output logic [TAG_W-1:0] tag
);

    logic [31:0] data_q [LINE_WORDS];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
        end else begin
            if (set_valid) begin
                valid <= 1'b1;
            end else if (clr_valid) begin
                valid <= 1'b0;
            end
            if (tag_we) begin
                tag <= tag_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            data_q[widx] <= wdata;
        end
    end

    assign rdata = data_q[ridx];

endmodule

// File: rtl/inst_fetch_responder.sv
// Instruction fetch responder: serves IF from a one-line buffer and refills
// it word by word over a req/ack handshake. IFR_STATS_EN adds hit/miss counters.
module inst_fetch_responder
    import mips_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic [31:0]       inst,
    output logic              hold_if,
    output logic              addr_err,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
`ifdef IFR_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W = IDX_W + 2;
    localparam int unsigned TAG_W = ADDR_W - OFF_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    ifr_state_t       state_q, state_d;
    logic [IDX_W-1:0] widx_q, widx_d;
    logic             flush_pending_q, flush_pending_d;

    logic [63:0]      pc_tag_full;
    logic             misaligned, tag_match, hit;
    logic             clr_valid, set_valid, tag_we, buf_we;
    logic [31:0]      buf_rdata;
    logic             buf_valid;
    logic [TAG_W-1:0] buf_tag;

    assign pc_tag_full = line_tag(64'(pc), LINE_WORDS);
    assign misaligned  = |pc[1:0];
    assign tag_match   = (pc_tag_full == 64'(buf_tag));
    assign hit         = buf_valid & tag_match & ~misaligned;

    ifr_line_buffer #(
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W)
    ) u_line (
        .clk       (clk),
        .rst       (rst),
        .clr_valid (clr_valid),
        .set_valid (set_valid),
        .tag_we    (tag_we),
        .tag_in    (pc_tag_full[TAG_W-1:0]),
        .we        (buf_we),
        .widx      (widx_q),
        .wdata     (mem_rdata),
        .ridx      (pc[OFF_W-1:2]),
        .rdata     (buf_rdata),
        .valid     (buf_valid),
        .tag       (buf_tag)
    );

    always_comb begin
        state_d         = state_q;
        widx_d          = widx_q;
        flush_pending_d = flush_pending_q;
        hold_if         = 1'b0;
        inst            = NOP_INST;
        addr_err        = misaligned;
        mem_req         = 1'b0;
        mem_addr        = '0;
        clr_valid       = 1'b0;
        set_valid       = 1'b0;
        tag_we          = 1'b0;
        buf_we          = 1'b0;

        if (rst) begin
            hold_if  = 1'b1;
            addr_err = 1'b0;
        end else begin
            case (state_q)
                IFR_IDLE: begin
                    clr_valid = flush;
                    if (!misaligned) begin
                        if (hit) begin
                            inst = buf_rdata;
                        end else begin
                            hold_if   = 1'b1;
                            tag_we    = 1'b1;
                            clr_valid = 1'b1;
                            widx_d    = '0;
                            state_d   = IFR_REFILL;
                        end
                    end
                end
                IFR_REFILL: begin
                    mem_req  = 1'b1;
                    mem_addr = {buf_tag, widx_q, 2'b00};
                    hold_if  = 1'b1;
                    if (flush) begin
                        flush_pending_d = 1'b1;
                    end
                    if (mem_ack) begin
                        buf_we = 1'b1;
                        widx_d = widx_q + IDX_W'(1);
                        if (widx_q == LAST_IDX) begin
                            // A flush seen at any point of the refill keeps the line invalid.
                            set_valid       = ~(flush_pending_q | flush);
                            flush_pending_d = 1'b0;
                            state_d         = IFR_IDLE;
                        end
                    end
                end
                default: state_d = IFR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IFR_IDLE;
            widx_q          <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            widx_q          <= widx_d;
            flush_pending_q <= flush_pending_d;
        end
    end

`ifdef IFR_STATS_EN
    logic idle_hit, idle_miss;

    assign idle_hit  = ~rst & (state_q == IFR_IDLE) & hit;
    assign idle_miss = ~rst & (state_q == IFR_IDLE) & ~hit & ~misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (idle_hit && hit_cnt != 32'hFFFF_FFFF) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (idle_miss && miss_cnt != 32'hFFFF_FFFF) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
